// File: rtl/coax_pkg.sv
// coax_pkg: shared state encoding and error codes for the coax receiver
package coax_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_QUIESCE, S_CV_HIGH, S_DATA, S_NEXT, S_END, S_ERROR
  } state_t;
  localparam logic [9:0] ERR_LOSS   = 10'd1;
  localparam logic [9:0] ERR_PARITY = 10'd2;
  localparam logic [9:0] ERR_END    = 10'd4;
endpackage

// File: rtl/coax_rx_edge.sv
// coax_rx_edge: two-flop synchronizer with rising/falling edge detect
module coax_rx_edge (
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  output logic rise_o,
  output logic fall_o,
  output logic level_o
);
  logic [2:0] sync_q;
  // two synchronizer stages plus one history stage for edge detection
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], rx_i};
  end
  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/coax_rx.sv
// coax_rx: bi-phase coax frame receiver delivering 10-bit words or a sticky error code
module coax_rx
  import coax_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       active,
  output logic       data_valid,
  output logic       error,
  output logic [9:0] data
);
  localparam int B  = CLOCKS_PER_BIT;
  localparam int W  = B / 4;
  localparam int TW = $clog2(2 * B + W + 2);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] W1_LO  = TW'(B - W);
  localparam logic [TW-1:0] W1_HI  = TW'(B + W);
  localparam logic [TW-1:0] W2_LO  = TW'(2 * B - W);
  localparam logic [TW-1:0] W2_HI  = TW'(2 * B + W);
  localparam logic [TW-1:0] T_SAT  = TW'(2 * B + W + 1);
  localparam logic [TW-1:0] T_HALF = TW'(B / 2);
  localparam logic [TW-1:0] T_FULL = TW'(B);

  logic rise, fall, level;
  coax_rx_edge u_edge (
    .clk    (clk),
    .reset  (reset),
    .rx_i   (rx),
    .rise_o (rise),
    .fall_o (fall),
    .level_o(level)
  );

  state_t          state_q, state_d;
  logic [TW-1:0]   t_q, t_d, t_inc;
  logic [2:0]      ones_q, ones_d;
  logic [3:0]      idx_q, idx_d;
  logic            par_q, par_d;
  logic [9:0]      word_q, word_d, data_d;
  logic            valid_d;
  logic            in1, in2, early;

  // t counts clocks since the last accepted mid-bit edge (edge cycle = 0), saturating past every timeout
  assign t_inc = (t_q == T_SAT) ? T_SAT : t_q + T_ONE;
  assign in1   = (t_q >= W1_LO) && (t_q <= W1_HI);
  assign in2   = (t_q >= W2_LO) && (t_q <= W2_HI);
  assign early = t_q < W1_LO;

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      ones_q     <= '0;
      idx_q      <= '0;
      par_q      <= 1'b0;
      word_q     <= '0;
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      ones_q     <= ones_d;
      idx_q      <= idx_d;
      par_q      <= par_d;
      word_q     <= word_d;
      data       <= data_d;
      data_valid <= valid_d;
    end
  end

  // next-state: start detection, bit sampling in the mid-bit window, parity and end checks
  always_comb begin
    state_d = state_q;
    t_d     = t_inc;
    ones_d  = ones_q;
    idx_d   = idx_q;
    par_d   = par_q;
    word_d  = word_q;
    data_d  = data;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_QUIESCE;
          ones_d  = 3'd1;
          t_d     = T_ONE;
        end
      end
      S_QUIESCE: begin
        if (rise && in1) begin
          ones_d = (ones_q >= 3'd5) ? ones_q : ones_q + 3'd1;
          t_d    = T_ONE;
        end else if (fall && in1) state_d = S_IDLE;
        else if (rise && ones_q >= 3'd5 && in2) begin
          state_d = S_CV_HIGH;
          t_d     = T_ONE;
        end else if ((rise && !early) || t_q > W2_HI) state_d = S_IDLE;
      end
      S_CV_HIGH: begin
        if (rise && in2) begin
          state_d = S_DATA;
          idx_d   = '0;
          par_d   = 1'b1;
          t_d     = T_ONE;
        end else if ((rise && !early) || t_q > W2_HI) state_d = S_IDLE;
      end
      S_DATA: begin
        if ((rise || fall) && in1) begin
          t_d   = T_ONE;
          par_d = par_q ^ rise;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd10) begin
            state_d = (par_q ^ rise) ? S_ERROR : S_NEXT;
            data_d  = (par_q ^ rise) ? ERR_PARITY : word_q;
            valid_d = !(par_q ^ rise);
          end else word_d = {word_q[8:0], rise};
        end else if (t_q > W1_HI) begin
          state_d = S_ERROR;
          data_d  = ERR_LOSS;
        end
      end
      S_NEXT: begin
        if ((rise || fall) && in1) begin
          t_d     = T_ONE;
          state_d = rise ? S_DATA : S_END;
          idx_d   = '0;
          par_d   = 1'b1;
        end else if (t_q > W1_HI) begin
          state_d = S_ERROR;
          data_d  = ERR_LOSS;
        end
      end
      S_END: begin
        if ((t_q == T_HALF || t_q == T_FULL) && !level) begin
          state_d = S_ERROR;
          data_d  = ERR_END;
        end else if (t_q == T_FULL) state_d = S_IDLE;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // status outputs decoded from the current state
  always_comb begin
    active = (state_q != S_IDLE) && (state_q != S_ERROR);
    error  = state_q == S_ERROR;
  end
endmodule

// File: tb/tb_coax_rx.sv
// tb_coax_rx: randomized frame stimulus checked against a frame-level behavioural model
module tb_coax_rx;
  localparam int B = 8;
  localparam logic [9:0] L = 10'b0110110011;

  logic clk = 1'b0, reset = 1'b1, rx = 1'b0;
  logic active, data_valid, error;
  logic [9:0] data;

  coax_rx #(.CLOCKS_PER_BIT(B)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .active    (active),
    .data_valid(data_valid),
    .error     (error),
    .data      (data)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, ctests = 0, cfails = 0;
  logic [9:0] exp_w[8];
  int exp_n = 0;
  logic [9:0] exp_err = '0;
  int rd_idx = 0;
  logic err_seen = 1'b0;
  logic [9:0] fw[4];
  logic fp[4];
  int fn, term;

  // every word pulse must match the next expected word; the first error must carry the expected code
  always @(negedge clk) begin
    if (reset) begin
      rd_idx = 0;
      err_seen = 1'b0;
    end else begin
      if (data_valid) begin
        ctests++;
        if (rd_idx >= exp_n) begin
          cfails++;
          $display("FAIL valid_pulse: got word %b, required no pulse", data);
        end else if (data !== exp_w[rd_idx]) begin
          cfails++;
          $display("FAIL valid_word: got %b required %b", data, exp_w[rd_idx]);
        end
        rd_idx++;
      end
      if (error && !err_seen) begin
        err_seen = 1'b1;
        ctests++;
        if (exp_err == 0 || data !== exp_err) begin
          cfails++;
          $display("FAIL error_code: got %0d required %0d", data, exp_err);
        end
      end
    end
  end

  task automatic check(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  function automatic logic par_of(input logic [9:0] w);
    return logic'(($countones(w) + 1) % 2);
  endfunction

  task automatic tx_set(input logic l);
    rx = l;
  endtask

  task automatic half;
    repeat (B / 2) @(negedge clk);
  endtask

  task automatic tx_bit(input logic b);
    tx_set(!b);
    half();
    tx_set(b);
    half();
  endtask

  task automatic tx_start_sequence;
    for (int i = 0; i < 5; i++) tx_bit(1'b1);
    tx_set(1'b0);
    repeat (3 * B / 2) @(negedge clk);
    tx_set(1'b1);
    repeat (3 * B / 2) @(negedge clk);
  endtask

  task automatic tx_end_sequence;
    tx_bit(1'b0);
    tx_set(1'b1);
    repeat (2 * B) @(negedge clk);
    tx_set(1'b0);
  endtask

  task automatic do_reset;
    rx = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_active", active, 0);
    check("rst_error", error, 0);
    check("rst_data", data, 0);
    check("rst_valid", data_valid, 0);
    reset = 1'b0;
  endtask

  task automatic final_checks;
    repeat (6 * B) @(negedge clk);
    check("end_active", active, 0);
    check("end_error", error, int'(exp_err != 0));
    check("end_data", data, exp_err != 0 ? int'(exp_err) : exp_n > 0 ? int'(exp_w[exp_n-1]) : 0);
    check("end_pulses", rd_idx, exp_n);
  endtask

  task automatic raw_begin(input logic [9:0] err);
    do_reset();
    exp_n = 0;
    exp_err = err;
  endtask

  task automatic run_frame;
    do_reset();
    exp_n = 0;
    exp_err = '0;
    for (int i = 0; i < fn; i++) begin
      if (term == 3 && i == fn - 1) begin
        exp_err = 10'd1;
        break;
      end
      if (fp[i] != par_of(fw[i])) begin
        exp_err = 10'd2;
        break;
      end
      exp_w[exp_n] = fw[i];
      exp_n++;
    end
    if (exp_err == 0) exp_err = term == 1 ? 10'd4 : term >= 2 ? 10'd1 : 10'd0;
    tx_start_sequence();
    for (int i = 0; i < fn; i++) begin
      tx_bit(1'b1);
      for (int b = 9; b >= 0; b--) tx_bit(fw[i][b]);
      if (!(term == 3 && i == fn - 1)) tx_bit(fp[i]);
    end
    if (term == 0) tx_end_sequence();
    else if (term == 1) begin
      tx_bit(1'b0);
      tx_set(1'b0);
    end
    final_checks();
  endtask

  initial begin
    check("model_parity_L", int'(par_of(L)), 1);
    raw_begin('0);
    tx_set(1'b1);
    repeat (4 * B) @(negedge clk);
    final_checks();
    for (int k = 1; k <= 5; k++) begin
      raw_begin('0);
      for (int i = 0; i < k; i++) tx_bit(1'b1);
      tx_set(1'b0);
      final_checks();
    end
    raw_begin('0);
    for (int i = 0; i < 5; i++) tx_bit(1'b1);
    tx_set(1'b0);
    repeat (3 * B / 2) @(negedge clk);
    tx_set(1'b1);
    repeat (4 * B) @(negedge clk);
    final_checks();
    raw_begin('0);
    tx_start_sequence();
    tx_set(1'b0);
    final_checks();
    raw_begin(10'd1);
    tx_start_sequence();
    tx_bit(1'b1);
    final_checks();
    check("lit_sync_static", data, 1);
    raw_begin('0);
    tx_start_sequence();
    tx_bit(1'b1);
    tx_bit(1'b0);
    tx_bit(1'b1);
    check("mid_frame_active", active, 1);
    do_reset();
    fn = 1; fw[0] = L; fp[0] = 1'b1; term = 3;
    run_frame();
    check("lit_no_parity", data, 1);
    fp[0] = 1'b0; term = 0;
    run_frame();
    check("lit_parity", data, 2);
    fp[0] = 1'b1; term = 2;
    run_frame();
    check("lit_static_after", data, 1);
    term = 1;
    run_frame();
    check("lit_bad_end", data, 4);
    term = 0;
    run_frame();
    check("lit_good_word", data, int'(L));
    check("lit_good_pulses", rd_idx, 1);
    fn = 2; fw[1] = 10'h2A5; fp[1] = par_of(fw[1]);
    run_frame();
    check("lit_two_pulses", rd_idx, 2);
    for (int n = 0; n < 30; n++) begin
      fn = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        fw[i] = 10'($urandom);
        fp[i] = ($urandom_range(0, 7) == 0) ? !par_of(fw[i]) : par_of(fw[i]);
      end
      term = $urandom_range(0, 3);
      run_frame();
    end
    $display("[TB] %0d tests run, %0d failed", tests + ctests, fails + cfails);
    $finish;
  end
endmodule
